aes_128_sched: RTL and testbench

- Round-robin scheduler that shares one fully pipelined aes_128 core between NUM_REQ requesters.
- The core has no stall and no valid, so this block does four things: picks one request per cycle, drives the core inputs, tracks in-flight blocks with a tag shift register, and captures results into an output FIFO.
- A credit limit on issue guarantees the FIFO can never overflow.
- Sits directly in front of aes_128 at the top of the crypto subsystem.

---
 rtl/aes_128_sched.sv | 175 +++++++++++++++++
 tb/tb_aes_128_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_sched.sv
// Round-robin front end that shares one fully pipelined aes_128 core between NUM_REQ requesters.
// Define AES_SCHED_STATS_EN to add the stat_issued / stat_stall counters.
module aes_128_sched #(
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LATENCY = 21,
    parameter int FIFO_DEPTH   = 32,
    parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_state,
    input  logic [NUM_REQ*128-1:0]   req_key,
    output logic [127:0]             core_state,
    output logic [127:0]             core_key,
    input  logic [127:0]             core_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [127:0]             rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(PIPE_LATENCY + 1);

    // Handshake: a block transfers on the rising edge where req_valid[i] && req_ready[i];
    // a response transfers on the rising edge where rsp_valid && rsp_ready.

    logic [ID_W-1:0]          r_rr_ptr;
    logic [PIPE_LATENCY-1:0]  r_tag_v;
    logic [ID_W-1:0]          r_tag_id [PIPE_LATENCY];
    logic [IW-1:0]            r_inflight;

    logic [127:0]             r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]          r_mem_id [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_valid;

    logic                     w_has_credit;
    logic                     w_grant;
    logic [ID_W-1:0]          w_grant_id;
    logic [ID_W-1:0]          w_rr_nxt;
    logic                     w_push;
    logic [ID_W-1:0]          w_push_id;
    logic                     w_pop;
    logic [CW-1:0]            w_count_nxt;
    int                       w_sel;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Queued plus in-flight results must always fit in the FIFO.
    assign w_has_credit = (int'(r_count) + int'(r_inflight)) < FIFO_DEPTH;

    always_comb begin
        int idx;
        idx        = 0;
        w_grant    = 1'b0;
        w_grant_id = '0;
        if (rst_n && w_has_credit) begin
            // Walk downward so the last hit is the nearest requester at or after r_rr_ptr.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (req_valid[idx]) begin
                    w_grant    = 1'b1;
                    w_grant_id = ID_W'(idx);
                end
            end
        end
    end

    assign w_sel      = int'(w_grant_id);
    assign req_ready  = w_grant ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign core_state = w_grant ? req_state[128*w_sel +: 128] : '0;
    assign core_key   = w_grant ? req_key[128*w_sel +: 128] : '0;
    assign w_rr_nxt   = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // The tag pipe shadows the core: the last stage lines up with the matching core_out.
    assign w_push    = r_tag_v[PIPE_LATENCY-1];
    assign w_push_id = r_tag_id[PIPE_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[PIPE_LATENCY-2:0], w_grant};
            r_tag_id[0] <= w_grant_id;
            for (int s = 1; s < PIPE_LATENCY; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_inflight  <= r_inflight + IW'(w_grant) - IW'(w_push);
        end
    end

    assign w_pop       = r_valid && rsp_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= core_out;
            r_mem_id[r_wr_ptr]   <= w_push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Head is masked while empty so the unreset storage never reaches the outputs.
    assign rsp_valid = r_valid;
    assign rsp_data  = r_valid ? r_mem_data[r_rd_ptr] : '0;
    assign rsp_id    = r_valid ? r_mem_id[r_rd_ptr] : '0;

`ifdef AES_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_grant) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if ((|req_valid) && !w_has_credit) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed bench for aes_128_sched; the aes_128 core is replaced by a pipelined stub that
// maps the FIPS-197 key/plaintext pair to its known ciphertext and scrambles anything else.
module tb_aes_128_sched;

    localparam int NR   = 4;
    localparam int L    = 21;
    localparam int DEP  = 32;
    localparam int ID_W = 2;
    localparam int EW   = ID_W + 128;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                  clk;
    logic                  rst_n;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [NR*128-1:0]     req_state;
    logic [NR*128-1:0]     req_key;
    logic [127:0]          core_state;
    logic [127:0]          core_key;
    logic [127:0]          core_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [127:0]          rsp_data;
    logic [ID_W-1:0]       rsp_id;
`ifdef AES_SCHED_STATS_EN
    logic [31:0]           stat_issued;
    logic [31:0]           stat_stall;
`endif

    aes_128_sched #(
        .NUM_REQ      (NR),
        .PIPE_LATENCY (L),
        .FIFO_DEPTH   (DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_key    (req_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef AES_SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- core stub ----------------
    function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
        if (s == FIPS_PT && k == FIPS_KEY) begin
            return FIPS_CT;
        end
        return s ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    logic [127:0] core_pipe [L];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(core_state, core_key);
        for (int k = 1; k < L; k++) begin
            core_pipe[k] <= core_pipe[k-1];
        end
    end
    assign core_out = core_pipe[L-1];

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]  exp_q[$];
    int             grant_log[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    int             last_acc = 0;
    int             last_rsp = 0;
    int             rsp_cnt  = 0;
    logic [127:0]   last_data;
    logic [ID_W-1:0] last_id;
    logic [127:0]   st [NR];
    logic [127:0]   ky [NR];
    int             seq [NR];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_state(input int i, input int s);
        return {8'(i), 24'h5a5a5a, 32'(s), 64'h0123456789abcdef};
    endfunction

    function automatic logic [127:0] mk_key(input int i, input int s);
        return {32'(s), 8'(i), 88'h00112233445566778899aa};
    endfunction

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            req_state[128*i +: 128] = st[i];
            req_key[128*i +: 128]   = ky[i];
        end
    endtask

    // ---------------- driver / monitor ----------------
    // Entered just after a rising edge; observes the coming edge at the falling edge before it.
    task automatic tick();
        int g;
        logic [EW-1:0] e;
        cyc++;
        @(negedge clk);
        check("ready_onehot0", 128'($onehot0(req_ready)), 128'd1);
        g = -1;
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                g = i;
            end
        end
        if (g >= 0) begin
            grant_log.push_back(g);
            exp_q.push_back({ID_W'(g), core_fn(st[g], ky[g])});
            last_acc = cyc;
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e[127:0]);
                check("rsp_id", 128'(rsp_id), 128'(e[EW-1:128]));
            end
            last_rsp  = cyc;
            last_data = rsp_data;
            last_id   = rsp_id;
            rsp_cnt++;
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            seq[g]++;
            st[g] = mk_state(g, seq[g]);
            ky[g] = mk_key(g, seq[g]);
            pack();
        end
    endtask

    task automatic do_reset(input logic [NR-1:0] v_after);
        rst_n = 1'b0;
        exp_q.delete();
        grant_log.delete();
        @(negedge clk);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_rsp_data", rsp_data, 128'd0);
        check("rst_rsp_id", 128'(rsp_id), 128'd0);
        check("rst_req_ready", 128'(req_ready), 128'd0);
        check("rst_core_state", core_state, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = v_after;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            tick();
        end
        check(tag, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic fips_run(input string tag);
        int n0;
        st[2] = FIPS_PT;
        ky[2] = FIPS_KEY;
        pack();
        req_valid = 4'b0100;
        n0 = grant_log.size();
        tick();
        req_valid = '0;
        check({tag, "_accept"}, 128'(grant_log.size() - n0), 128'd1);
        n0 = rsp_cnt;
        for (int i = 0; i < L + 10 && rsp_cnt == n0; i++) begin
            tick();
        end
        check({tag, "_seen"}, 128'(rsp_cnt - n0), 128'd1);
        check({tag, "_latency"}, 128'(last_rsp - last_acc), 128'(L + 1));
        check({tag, "_data"}, last_data, FIPS_CT);
        check({tag, "_id"}, 128'(last_id), 128'd2);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int bad;
        int n0;
        int hi;
        int exp4 [7];
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            st[i]  = mk_state(i, 0);
            ky[i]  = mk_key(i, 0);
        end
        pack();
        #1;
        do_reset('0);

        // FIPS-197 vector through requester 2
        rsp_ready = 1'b1;
        fips_run("fips");

        // all requesters saturating: strict 0,1,2,3 rotation, one grant per cycle
        do_reset('0);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (16) tick();
        req_valid = '0;
        check("rr_full_count", 128'(grant_log.size()), 128'd16);
        bad = 0;
        for (int i = 0; i < grant_log.size(); i++) begin
            if (grant_log[i] != (i % 4)) bad++;
        end
        check("rr_full_order", 128'(bad), 128'd0);
        n0 = rsp_cnt;
        drain("rr_full_drain");
        check("rr_full_rsp", 128'(rsp_cnt - n0), 128'd16);

        // credit limit: 32 accepted with the output stalled, then issue resumes
        do_reset('0);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (60) tick();
        check("credit_accepted", 128'(grant_log.size()), 128'd32);
        check("credit_ready_low", 128'(req_ready), 128'd0);
        check("credit_rsp_valid", 128'(rsp_valid), 128'd1);
        n0 = rsp_cnt;
        rsp_ready = 1'b1;
        tick();
        check("credit_hold_one", 128'(grant_log.size()), 128'd32);
        tick();
        check("credit_resume", 128'(grant_log.size()), 128'd33);
        for (int i = 0; i < 100 && grant_log.size() < 40; i++) begin
            tick();
        end
        req_valid = '0;
        check("credit_total", 128'(grant_log.size()), 128'd40);
        drain("credit_drain");
        check("credit_rsp", 128'(rsp_cnt - n0), 128'd40);
`ifdef AES_SCHED_STATS_EN
        check("stat_issued", 128'(stat_issued), 128'd40);
        check("stat_stall", 128'(stat_stall), 128'd29);
`endif

        // sparse requesters with rr_ptr at 2, then requester 0 joins
        do_reset('0);
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        repeat (3) tick();
        req_valid = 4'b1011;
        repeat (3) tick();
        req_valid = '0;
        exp4 = '{1, 3, 1, 3, 0, 1, 3};
        check("rr_sparse_count", 128'(grant_log.size()), 128'd7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++) begin
            check("rr_sparse_id", 128'(grant_log[i]), 128'(exp4[i]));
        end
        drain("rr_sparse_drain");

        // reset with blocks in flight: nothing comes out, then a fresh block works
        do_reset('0);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (10) tick();
        check("mid_inflight", 128'(grant_log.size()), 128'd10);
        do_reset('0);
        hi = 0;
        repeat (L + 5) begin
            tick();
            if (rsp_valid) hi++;
        end
        check("mid_rsp_quiet", 128'(hi), 128'd0);
        fips_run("post_rst");
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
